// File: rtl/dsss_descramble_sync_detect_if.sv
// Bit-stream bus between the differential decoder, this descrambler/sync
// detector and the downstream PHY header detector.
interface dsss_descramble_sync_detect_if;
  logic raw_bit;
  logic raw_valid;
  logic rearm;
  logic data_bit;
  logic data_valid;
  logic preamble_detected;
  logic sfd_detected;
  logic locked;

  // Upstream/downstream side: supplies raw bits and rearm, consumes results
  modport master (
    output raw_bit, raw_valid, rearm,
    input  data_bit, data_valid, preamble_detected, sfd_detected, locked
  );

  // Descrambler/sync detector side
  modport slave (
    input  raw_bit, raw_valid, rearm,
    output data_bit, data_valid, preamble_detected, sfd_detected, locked
  );
endinterface

// File: rtl/dsss_descramble_sync_detect.sv
// 802.11b 1 Mbps self-synchronous descrambler (z^-7 + z^-4 + 1) with
// long-preamble SYNC detection and SFD search.
module dsss_descramble_sync_detect #(
  parameter int unsigned SYNC_THRESH = 64,
  parameter int unsigned SFD_TIMEOUT = 160,
  parameter logic [15:0] SFD_PATTERN = 16'h05CF
) (
  input logic                          clk,
  input logic                          reset,
  dsss_descramble_sync_detect_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, SYNC_HUNT, LOCKED} state_t;

  state_t      state;
  logic [6:0]  scr;
  // Only the 15 most recent bits need storing: the 16-bit compare window
  // is always formed together with the incoming descrambled bit.
  logic [14:0] hist;
  logic [7:0]  ones_cnt;
  logic [7:0]  to_cnt;

  logic        d;
  logic [15:0] hist_nxt;
  logic [7:0]  ones_nxt;
  logic        sfd_hit;
  logic        timeout;

  // Descrambled bit, next history window, next run length and FSM conditions
  always_comb begin
    d        = bus.raw_bit ^ scr[3] ^ scr[6];
    hist_nxt = {hist, d};
    ones_nxt = '0;
    if (d) ones_nxt = (ones_cnt == '1) ? ones_cnt : ones_cnt + 8'd1;
    sfd_hit  = (hist_nxt == SFD_PATTERN);
    timeout  = (to_cnt == 8'(SFD_TIMEOUT - 1));
  end

  // Descrambler shift register and registered data output, active in every state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scr            <= '0;
      bus.data_bit   <= 1'b0;
      bus.data_valid <= 1'b0;
    end else begin
      bus.data_valid <= bus.raw_valid;
      if (bus.raw_valid) begin
        scr          <= {scr[5:0], bus.raw_bit};
        bus.data_bit <= d;
      end
    end
  end

  // Sync/SFD state machine with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= SEARCH;
      hist                  <= '0;
      ones_cnt              <= '0;
      to_cnt                <= '0;
      bus.preamble_detected <= 1'b0;
      bus.sfd_detected      <= 1'b0;
      bus.locked            <= 1'b0;
    end else begin
      bus.sfd_detected <= 1'b0;
      if (bus.rearm) begin
        // History is wiped only when leaving LOCKED; otherwise it keeps tracking.
        if (state == LOCKED) hist <= '0;
        else if (bus.raw_valid) hist <= hist_nxt[14:0];
        state                 <= SEARCH;
        ones_cnt              <= '0;
        to_cnt                <= '0;
        bus.preamble_detected <= 1'b0;
        bus.locked            <= 1'b0;
      end else if (bus.raw_valid) begin
        hist     <= hist_nxt[14:0];
        ones_cnt <= ones_nxt;
        case (state)
          SEARCH: begin
            if (ones_nxt == 8'(SYNC_THRESH)) begin
              state                 <= SYNC_HUNT;
              to_cnt                <= '0;
              bus.preamble_detected <= 1'b1;
            end
          end
          SYNC_HUNT: begin
            if (sfd_hit) begin
              state                 <= LOCKED;
              bus.sfd_detected      <= 1'b1;
              bus.preamble_detected <= 1'b0;
              bus.locked            <= 1'b1;
            end else if (timeout) begin
              state                 <= SEARCH;
              ones_cnt              <= '0;
              bus.preamble_detected <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
